// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared types and helpers for the scan sequencer that drives the 2-to-4
// one-hot decoder.
//   state_t    : sequencer states (idle, blanking gap, decoder enabled)
//   sel_encode : slot index -> {i0, i1} decoder select bits
//   next_slot  : next enabled slot searching upward from slot+1 with wrap
// -----------------------------------------------------------------------------
package scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } state_t;

   // The decoder lights a_k for i0=~k[1], i1=~k[0], so slot k maps to the
   // inverted index bits.
   function automatic logic [1:0] sel_encode(input logic [1:0] slot_idx);
      return {~slot_idx[1], ~slot_idx[0]};
   endfunction

   // Walks slot+1, slot+2, slot+3 and finally slot itself (wrap 3->0), so a
   // mask with only the current bit set repeats the same slot. Calling it with
   // slot=3 yields the lowest set bit, which is what a fresh start needs.
   // With an empty mask the slot is returned unchanged.
   function automatic logic [1:0] next_slot(input logic [1:0] slot_idx,
                                            input logic [3:0] slot_mask);
      logic [1:0] idx;
      logic       found;
      next_slot = slot_idx;
      found     = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = slot_idx + 2'(k);
         if (!found && slot_mask[idx]) begin
            next_slot = idx;
            found     = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Loadable down-counter shared by the blanking gap and the ON window.
// A load of N followed by N enabled cycles raises done on the Nth cycle.
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset (count clears to 0)
//   load     in  : load load_val into the counter (wins over counting)
//   load_val in  : duration in cycles, >= 1
//   en       in  : count enable; low freezes the counter and masks done
//   done     out : 1-cycle pulse on the final enabled cycle of the duration
// -----------------------------------------------------------------------------
module scan_timer #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // Counter register: a load restarts the duration; otherwise it counts down
   // while enabled and parks at zero so an unused timer never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   // Done fires on the cycle the count reads 1, i.e. the last cycle of the
   // loaded duration, so the caller can switch phase on that same edge.
   assign done = en && (count == CNT_W'(1));

endmodule

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
// Time-multiplexing sequencer for the 2-to-4 one-hot decoder. It steps through
// the slots enabled in mask, holding each decoder output for PRESCALE cycles
// after a BLANK-cycle dead time with e=0. All outputs are registered.
// Optional build macro: SCAN_HOLD_EN adds a hold input that freezes the scan.
//   clk         in  : system clock, rising edge
//   rst_n       in  : asynchronous active-low reset
//   start       in  : 1-cycle pulse, begin scanning (ignored while busy)
//   stop        in  : 1-cycle pulse, abort scanning (wins over start/hold)
//   mask        in  : slot enables, bit k = slot k participates
//   hold        in  : (SCAN_HOLD_EN only) freeze timer, state and slot
//   e           out : decoder enable
//   i0, i1      out : decoder select bits
//   slot        out : current/pending slot index
//   slot_strobe out : 1-cycle pulse on the first ON cycle of each slot
//   busy        out : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int PRESCALE = 1000,
   parameter int BLANK    = 2,
   parameter int CNT_W    = $clog2(PRESCALE + BLANK + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] mask,
`ifdef SCAN_HOLD_EN
   input  logic       hold,
`endif
   output logic       e,
   output logic       i0,
   output logic       i1,
   output logic [1:0] slot,
   output logic       slot_strobe,
   output logic       busy
);

   localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(PRESCALE);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK);

   state_t           state, state_n;
   logic [1:0]       slot_n;
   logic             sel_upd;
   logic             strobe_n;
   logic             go_slot;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_en;
   logic             timer_done;
   logic             hold_act;

`ifdef SCAN_HOLD_EN
   assign hold_act = hold;
`else
   assign hold_act = 1'b0;
`endif

   // The timer only runs while a slot phase is in progress; hold simply
   // withholds its enable so the remaining duration is preserved.
   assign timer_en = (state != ST_IDLE) && !hold_act;

   scan_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .en       (timer_en),
      .done     (timer_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic. Entering a slot (from start or from an advance) always
   // goes through the blanking gap unless BLANK is zero, in which case the ON
   // window starts immediately and needs its strobe right away. The slot is
   // only re-chosen on leaving IDLE or leaving ON, so the select lines stay
   // put for the whole blank+ON period of a slot.
   always_comb begin
      state_n    = state;
      slot_n     = slot;
      sel_upd    = 1'b0;
      strobe_n   = 1'b0;
      go_slot    = 1'b0;
      timer_load = 1'b0;
      timer_val  = '0;

      if (stop) begin
         state_n = ST_IDLE;
      end else if (!hold_act) begin
         unique case (state)
            ST_IDLE: begin
               if (start && (mask != 4'b0000)) begin
                  slot_n  = next_slot(2'd3, mask);
                  sel_upd = 1'b1;
                  go_slot = 1'b1;
               end
            end
            ST_BLANK: begin
               if (timer_done) begin
                  state_n    = ST_ON;
                  timer_load = 1'b1;
                  timer_val  = ON_LOAD;
                  strobe_n   = 1'b1;
               end
            end
            ST_ON: begin
               if (timer_done) begin
                  if (mask == 4'b0000) begin
                     state_n = ST_IDLE;
                  end else begin
                     slot_n  = next_slot(slot, mask);
                     sel_upd = 1'b1;
                     go_slot = 1'b1;
                  end
               end
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase

         if (go_slot) begin
            timer_load = 1'b1;
            if (BLANK > 0) begin
               state_n   = ST_BLANK;
               timer_val = BLANK_LOAD;
            end else begin
               state_n   = ST_ON;
               timer_val = ON_LOAD;
               strobe_n  = 1'b1;
            end
         end
      end
   end

   // Registered outputs, all derived from the next state so they line up with
   // the state register. The select bits are kept in their own flops rather
   // than decoded from slot because reset must drive them to 0, not to the
   // slot-0 encoding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e           <= 1'b0;
         busy        <= 1'b0;
         slot_strobe <= 1'b0;
         slot        <= 2'd0;
         i0          <= 1'b0;
         i1          <= 1'b0;
      end else begin
         e           <= (state_n == ST_ON);
         busy        <= (state_n != ST_IDLE);
         slot_strobe <= strobe_n;
         if (sel_upd) begin
            slot     <= slot_n;
            {i0, i1} <= sel_encode(slot_n);
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
// Self-checking bench for scan_sequencer with PRESCALE=4, BLANK=1. A reference
// model tracks the scan as a position within the slot period plus the chosen
// slot, and every cycle the DUT outputs are compared against it. Build with
// SCAN_HOLD_EN to also exercise the hold input.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

   localparam int P = 4;
   localparam int B = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [3:0] mask;
   logic       hold_tb;
   logic       e, i0, i1, slot_strobe, busy;
   logic [1:0] slot;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit         m_run;
   int         m_pos;
   int         m_slot;
   logic       m_i0, m_i1, m_strobe;

   scan_sequencer #(
      .PRESCALE (P),
      .BLANK    (B)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .mask        (mask),
`ifdef SCAN_HOLD_EN
      .hold        (hold_tb),
`endif
      .e           (e),
      .i0          (i0),
      .i1          (i1),
      .slot        (slot),
      .slot_strobe (slot_strobe),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Compare one observed value against the bench's expectation.
   task automatic checkBit(input string tag, input logic [1:0] obs, input logic [1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic modelReset();
      m_run    = 0;
      m_pos    = 0;
      m_slot   = 0;
      m_i0     = 1'b0;
      m_i1     = 1'b0;
      m_strobe = 1'b0;
   endtask

   // Advance the model by one clock edge with the inputs sampled on that edge.
   task automatic modelStep(input logic st, input logic sp, input logic [3:0] mk, input logic hd);
      int nxt;
      bit stepped;
      stepped = 0;
      if (sp) begin
         m_run = 0;
      end else if (hd) begin
         stepped = 0;
      end else if (!m_run) begin
         if (st && mk != 4'b0000) begin
            m_run = 1;
            m_pos = 0;
            for (int k = 3; k >= 0; k--) if (mk[k]) m_slot = k;
            m_i0 = ~m_slot[1];
            m_i1 = ~m_slot[0];
            stepped = 1;
         end
      end else begin
         stepped = 1;
         if (m_pos == B + P - 1) begin
            if (mk == 4'b0000) begin
               m_run = 0;
            end else begin
               nxt = -1;
               for (int k = 1; k <= 4; k++)
                  if (nxt < 0 && mk[(m_slot + k) % 4]) nxt = (m_slot + k) % 4;
               m_slot = nxt;
               m_i0   = ~m_slot[1];
               m_i1   = ~m_slot[0];
               m_pos  = 0;
            end
         end else begin
            m_pos++;
         end
      end
      m_strobe = stepped && m_run && (m_pos == B);
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model, then
   // drop the pulse inputs a little after the edge.
   task automatic applyStimulus(input logic st, input logic sp, input logic [3:0] mk, input logic hd);
      start   = st;
      stop    = sp;
      mask    = mk;
      hold_tb = hd;
      @(posedge clk);
      modelStep(st, sp, mk, hd);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic checkOutput();
      checkBit("e",      {1'b0, e},           {1'b0, m_run && (m_pos >= B)});
      checkBit("busy",   {1'b0, busy},        {1'b0, m_run});
      checkBit("slot",   slot,                2'(m_slot));
      checkBit("i0",     {1'b0, i0},          {1'b0, m_i0});
      checkBit("i1",     {1'b0, i1},          {1'b0, m_i1});
      checkBit("strobe", {1'b0, slot_strobe}, {1'b0, m_strobe});
   endtask

   initial begin
      int e_cnt;
      int s_cnt;
      logic [3:0] rmask;
      logic       rst_, rsp, rhd;

      rst_n   = 1'b0;
      start   = 1'b0;
      stop    = 1'b0;
      mask    = 4'b0000;
      hold_tb = 1'b0;
      modelReset();
      #2;
      checkOutput();
      #10;
      rst_n = 1'b1;

      // Full mask: slots 0..3 in order, wrapping back to slot 0 at cycle 22.
      $display("[TB] full mask scan");
      for (int c = 1; c <= 22; c++) begin
         applyStimulus(c == 1, 1'b0, 4'b1111, 1'b0);
         checkOutput();
         if (c == 1) checkBit("blank_c1", {1'b0, e}, 2'd0);
         if (c == 2) checkBit("strobe_c2", {1'b0, slot_strobe}, 2'd1);
         if (c == 7) checkBit("slot1_c7", {i0, i1}, 2'b10);
         if (c == 22) checkBit("wrap_c22", {e, slot_strobe}, 2'b11);
         if (c == 22) checkBit("wrap_slot_c22", slot, 2'd0);
      end
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b0);
      checkOutput();

      // Sparse mask: only slots 0 and 2 ever get an ON window.
      $display("[TB] mask 0101");
      for (int c = 1; c <= 22; c++) begin
         applyStimulus(c == 1, 1'b0, 4'b0101, 1'b0);
         checkOutput();
         checkBit("no_odd_on", {1'b0, e & slot[0]}, 2'd0);
      end
      applyStimulus(1'b0, 1'b1, 4'b0101, 1'b0);
      checkOutput();

      // Empty-mask start and simultaneous start/stop must both stay idle.
      $display("[TB] ignored starts");
      applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
      checkOutput();
      checkBit("empty_start_busy", {1'b0, busy}, 2'd0);
      applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0);
      checkOutput();
      checkBit("start_stop_busy", {1'b0, busy}, 2'd0);

      // Mask cleared during slot 2: scan ends after slot 2 with slot held.
      $display("[TB] mask cleared mid-slot");
      for (int c = 1; c <= 18; c++) begin
         applyStimulus(c == 1, 1'b0, (c >= 13) ? 4'b0000 : 4'b1111, 1'b0);
         checkOutput();
         if (c == 18) checkBit("cleared_slot", slot, 2'd2);
         if (c == 18) checkBit("cleared_busy", {busy, e}, 2'b00);
      end

      // Stop on the second ON cycle of slot 1.
      $display("[TB] stop mid-slot");
      for (int c = 1; c <= 10; c++) begin
         applyStimulus(c == 1, c == 9, 4'b1111, 1'b0);
         checkOutput();
         if (c == 9) checkBit("stop_slot", slot, 2'd1);
         if (c == 9) checkBit("stop_busy_e", {busy, e}, 2'b00);
      end

      // Asynchronous reset in the middle of an ON window, then restart.
      $display("[TB] async reset");
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(c == 1, 1'b0, 4'b1111, 1'b0);
         checkOutput();
      end
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         applyStimulus(c == 1, 1'b0, 4'b0110, 1'b0);
         checkOutput();
         if (c == 2) checkBit("restart_slot", slot, 2'd1);
      end
      applyStimulus(1'b0, 1'b1, 4'b0110, 1'b0);
      checkOutput();

`ifdef SCAN_HOLD_EN
      // Hold for 3 cycles inside the first ON window stretches it to 7.
      $display("[TB] hold");
      e_cnt = 0;
      s_cnt = 0;
      for (int c = 1; c <= 9; c++) begin
         applyStimulus(c == 1, 1'b0, 4'b0001, (c >= 4) && (c <= 6));
         checkOutput();
         if (e) e_cnt++;
         if (slot_strobe) s_cnt++;
      end
      checkBit("hold_on_len", 2'(e_cnt), 2'(7));
      checkBit("hold_strobes", 2'(s_cnt), 2'd1);
      applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0);
      checkOutput();
`endif

      // Randomized traffic against the model.
      $display("[TB] random traffic");
      rmask = 4'b1111;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(15) == 0) rmask = 4'($urandom);
         rst_ = ($urandom_range(7) == 0);
         rsp  = ($urandom_range(39) == 0);
`ifdef SCAN_HOLD_EN
         rhd  = ($urandom_range(9) == 0);
`else
         rhd  = 1'b0;
`endif
         applyStimulus(rst_, rsp, rmask, rhd);
         checkOutput();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Time-multiplexing sequencer that drives the enable and 2-bit select inputs of the team's 2-to-4 one-hot decoder. It steps through the four decoder outputs and holds each one for a programmable dwell time. A blanking gap between slots keeps two outputs from overlapping. Slots can be masked off and are skipped. Typical use is scanning display digits or rows.

Parameters:
PRESCALE, 1000, ON cycles per slot (>=1)
BLANK, 2, dead-time cycles with e=0 before each slot (>=0)
CNT_W, $clog2(PRESCALE+BLANK+1), internal counter width (derived, do not override)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse, begin scanning
stop  in  1  1-cycle pulse, abort scanning
mask  in  4  slot enables, bit k = slot k participates
e  out  1  decoder enable
i0  out  1  decoder select bit i0
i1  out  1  decoder select bit i1
slot  out  2  index of the current/pending slot
slot_strobe  out  1  1-cycle pulse on the first ON cycle of each slot
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; e=0, i0=0, i1=0, slot=0, slot_strobe=0, busy=0; counter=0.
- All outputs are registered.
- Select encoding, so that decoder output a_k is the active one when slot=k: i0 = ~slot[1], i1 = ~slot[0].
  - slot0 -> i0=1, i1=1
  - slot1 -> i0=1, i1=0
  - slot2 -> i0=0, i1=1
  - slot3 -> i0=0, i1=0
- States: IDLE, BLANK, ON.
- IDLE:
  - e=0.
  - start=1, stop=0, mask!=0: slot <= lowest set bit of mask. Next state is BLANK, or ON if BLANK==0.
  - start with mask==0: ignored, stay IDLE.
- BLANK: e=0 for exactly BLANK cycles, then ON.
- ON:
  - e=1 for exactly PRESCALE cycles; slot_strobe=1 on the first ON cycle.
  - After the last ON cycle, slot <= next set bit of mask searching upward from slot+1 with wrap 3->0. If only the current bit is set, the same slot repeats.
  - Then go to BLANK (or ON if BLANK==0).
- Slot period = PRESCALE+BLANK cycles.
- i0/i1/slot change only on the edge that leaves ON or leaves IDLE. With BLANK>0 they therefore never change while e=1.
- mask is sampled only at a slot advance and at start. Mid-slot mask changes take effect at the next advance.
- mask==0 at an advance: go to IDLE, e=0, busy=0, slot holds.
- stop in any state: next cycle state=IDLE, e=0, slot_strobe=0; slot/i0/i1 hold their values.
- start and stop in the same cycle: stop wins.
- start while busy: ignored.
- Reset mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
SCAN_HOLD_EN
- Defined: adds input port hold (1 bit). While hold=1 the counter, state and slot freeze and e keeps its current value. slot_strobe is suppressed during hold. stop still overrides hold.
- Undefined: no hold port; the scan free-runs.

Decomposition:
- Package scan_pkg:
  - state enum {IDLE, BLANK, ON}
  - function sel_encode(slot) -> {i0,i1}
  - function next_slot(slot, mask) -> 2-bit next enabled index
- One sub-module, scan_timer: load value plus down-counter with a 1-cycle done pulse. It is reused for both BLANK and ON durations.

Test Plan:
- PRESCALE=4, BLANK=1, mask=1111, start at cycle 0 (registered 1-cycle gaps):
  - e=0 at cycle 1; e=1 cycles 2-5 with slot0 (i0=1, i1=1), strobe at cycle 2
  - e=0 at cycle 6; e=1 cycles 7-10 with slot1 (i0=1, i1=0)
  - slot3 then wraps to slot0 at cycle 22.
- mask=0101: slot sequence 0,2,0,2. i0/i1 alternate between 11 and 01; no ON window for slots 1 or 3.
- mask=0000 plus start: stays IDLE, busy=0, e=0. With mask=1111, mask cleared during slot2: at the end of slot2 returns to IDLE with e=0 and slot=2.
- stop on the 2nd ON cycle of slot1: e=0 and busy=0 next cycle, slot=1 held. start and stop in the same cycle from IDLE: stays IDLE.
- rst_n asserted mid-ON: e/i0/i1/slot/busy go to 0 asynchronously. After release, a start restarts from the lowest enabled slot.
- SCAN_HOLD_EN, hold=1 for 3 cycles during ON: e stays 1 and the ON window is extended to 7 cycles total. No second strobe.
